sensor_array: RTL and testbench
===============================

# sensor_array

Parametrised multi-channel sensor monitor, successor to the single-channel sensor controller. It fetches a per-channel event threshold from the on-board ROM after reset and on request. It then synchronises, debounces and counts rising events on CHANNELS sensor inputs, and lights each channel's LED once that channel's count reaches its threshold. It sits between the board sensor pins and LEDs, and owns the ROM read interface. Memory is clocked from the system clock; there is no separate memory clock.

## Interface
- CHANNELS, 4: number of sensor/LED channels (1..16)
- DATA_W, 8: ROM word width, threshold width and event-counter width
- ADDR_W, 4: ROM address width
- ROM_BASE, 0: ROM address of channel 0's threshold; channel i reads ROM_BASE+i; CHANNELS+ROM_BASE <= 2**ADDR_W
- DEBOUNCE, 3: consecutive stable cycles required to accept a level change (>=1)
- clk  in  1  system clock; one clock; all logic on its rising edge
- reset_n  in  1  reset, asynchronous and active-low
- sensor  in  CHANNELS  raw asynchronous sensor levels
- clear  in  1  synchronous pulse; zeroes all event counters
- reload  in  1  synchronous pulse; re-fetches all thresholds from ROM
- led  out  CHANNELS  per-channel LED, registered
- busy  out  1  high while thresholds are being loaded
- rom_addr  out  ADDR_W  ROM address
- rom_re  out  1  ROM read enable
- rom_ce  out  1  ROM chip enable
- rom_data  in  DATA_W  ROM read data, valid the cycle after rom_re/rom_ce are sampled high

## Operation
- FSM states: IDLE, LOAD_REQ, LOAD_WAIT, RUN; reset state is IDLE with idx=0.
- IDLE -> LOAD_REQ unconditionally on the first clock after reset release.
- LOAD_REQ: rom_ce=1, rom_re=1, rom_addr=ROM_BASE+idx. Next state is LOAD_WAIT.
- LOAD_WAIT: rom_ce=rom_re=0; thr[idx] <= rom_data at the end of the cycle.
  - If idx==CHANNELS-1: idx <= 0, go to RUN.
  - Otherwise: idx++, go to LOAD_REQ.
- RUN: rom_ce=rom_re=0. On reload=1, go to LOAD_REQ with idx=0.
- busy = 1 in every state except RUN. ROM outputs are decoded from the state register only (Moore). rom_addr holds 0 outside LOAD_REQ.
- Per-channel input path: two-flop synchroniser to s2, then debounce filter to filt.
  - The debounce counter counts cycles with s2 != filt and resets to 0 whenever s2 == filt.
  - When it reaches DEBOUNCE, filt <= s2 and the counter resets.
- Event counter cnt[i] (DATA_W bits) increments on the edge where filt[i] goes 0->1. It saturates at 2**DATA_W-1 and never wraps.
- led[i] <= (thr[i] != 0) && (cnt[i] >= thr[i]). A threshold of 0 disables the channel: its LED stays 0 while its counter still runs.
- Counter clear conditions, highest priority first:
  - Any state other than RUN: all cnt held at 0.
  - clear=1 in RUN: all cnt <= 0, and a simultaneous filt rise is discarded.
- reload in RUN also zeroes the counters, since they are held at 0 during the load. led falls one cycle after the counters clear.
- reload while busy=1 is ignored. clear while busy=1 has no further effect.
- Debounce filters keep running in every state. A level already high when RUN is entered produces no event until it falls and rises again.
- Asynchronous reset at any point, including mid-load:
  - FSM -> IDLE, idx=0.
  - All thr, cnt, filt, synchroniser and debounce registers -> 0.

## Timing
- Reset values: led=0, busy=1, rom_ce=0, rom_re=0, rom_addr=0.
- Load takes 1 + 2*CHANNELS cycles after reset release; busy falls on edge 1+2*CHANNELS. With defaults this is 9 cycles.
- Reload in RUN: busy rises on the next edge and falls 2*CHANNELS edges later.
- Sensor latency, with sensor rising just before edge 0 and held high:
  - s2 = 1 after edge 1.
  - filt and cnt update at edge 1+DEBOUNCE.
  - led updates at edge 2+DEBOUNCE.
  - With DEBOUNCE=3: count at edge 4, LED at edge 5.
- A pulse on s2 shorter than DEBOUNCE cycles produces no event. The same applies to glitches on the falling side.
- Maximum event rate: one per 2*DEBOUNCE cycles per channel.

## Test plan
- ROM load: ROM[0..3]=2,0,5,1; release reset -> rom_re/rom_ce high for one cycle each at addresses 0,1,2,3, spaced 2 cycles apart; busy low after 9 cycles; thr={2,0,5,1}.
- Debounce: sensor[0] high for 2 cycles, then high for 3 cycles -> first pulse ignored; cnt[0]=1 after the second pulse; with thr[0]=2, led[0] stays 0; a third valid pulse gives led[0]=1 exactly 5 cycles after the rising edge.
- Disabled and saturating: 300 valid pulses on sensor[1] (thr=0) -> led[1]=0 and cnt[1]=255; 1 pulse on sensor[3] (thr=1) -> led[3]=1.
- Clear collision: assert clear on the edge where filt[2] rises -> cnt[2]=0; all LEDs 0 on the following cycle.
- Reload: change ROM[0] to 1 and pulse reload in RUN -> busy high for 8 cycles; counters stay 0; one pulse on sensor[0] then sets led[0]; reload pulsed while busy is ignored.
- Reset mid-load: drop reset_n during the third LOAD_WAIT -> all outputs return to reset values; after release, a full 4-channel load restarts from address 0.

Source files
------------

// File: rtl/sensor_array_if.sv
// ROM read bus between the sensor monitor (master) and the board ROM (slave).
interface sensor_array_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_re;
    logic              rom_ce;
    logic [DATA_W-1:0] rom_data;

    modport master (output rom_addr, output rom_re, output rom_ce, input rom_data);
    modport slave  (input rom_addr, input rom_re, input rom_ce, output rom_data);
endinterface

// File: rtl/sensor_array.sv
// Multi-channel sensor monitor: loads per-channel thresholds from ROM, then
// synchronises, debounces and counts rising events, lighting LEDs at threshold.
module sensor_array #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned ROM_BASE = 0,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] sensor,
    input  logic                clear,
    input  logic                reload,
    output logic [CHANNELS-1:0] led,
    output logic                busy,
    sensor_array_if.master      rom
);
    localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned DEB_W = $clog2(DEBOUNCE + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CHANNELS - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE - 1);
    localparam logic [DATA_W-1:0] CNT_MAX  = '1;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(ROM_BASE);

    typedef enum logic [1:0] {IDLE, LOAD_REQ, LOAD_WAIT, RUN} state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic              r_busy;
    logic              r_rom_ce;
    logic              r_rom_re;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [DATA_W-1:0] r_thr [CHANNELS];

    // Load sequencer; ROM strobes are registered alongside the state they decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_busy     <= 1'b1;
            r_rom_ce   <= 1'b0;
            r_rom_re   <= 1'b0;
            r_rom_addr <= '0;
            for (int i = 0; i < CHANNELS; i++) r_thr[i] <= '0;
        end else begin
            r_rom_ce   <= 1'b0;
            r_rom_re   <= 1'b0;
            r_rom_addr <= '0;
            case (r_state)
                IDLE: begin
                    r_state    <= LOAD_REQ;
                    r_idx      <= '0;
                    r_rom_ce   <= 1'b1;
                    r_rom_re   <= 1'b1;
                    r_rom_addr <= BASE;
                end
                LOAD_REQ: begin
                    r_state <= LOAD_WAIT;
                end
                LOAD_WAIT: begin
                    r_thr[r_idx] <= rom.rom_data;
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_state <= RUN;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idx      <= r_idx + IDX_W'(1);
                        r_state    <= LOAD_REQ;
                        r_rom_ce   <= 1'b1;
                        r_rom_re   <= 1'b1;
                        r_rom_addr <= BASE + ADDR_W'(r_idx) + ADDR_W'(1);
                    end
                end
                RUN: begin
                    if (reload) begin
                        r_state    <= LOAD_REQ;
                        r_idx      <= '0;
                        r_busy     <= 1'b1;
                        r_rom_ce   <= 1'b1;
                        r_rom_re   <= 1'b1;
                        r_rom_addr <= BASE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_idx   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign rom.rom_ce   = r_rom_ce;
    assign rom.rom_re   = r_rom_re;
    assign rom.rom_addr = r_rom_addr;

    for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
        logic              r_s1;
        logic              r_s2;
        logic              r_filt;
        logic              r_led;
        logic [DEB_W-1:0]  r_deb;
        logic [DATA_W-1:0] r_cnt;
        logic              w_rise;

        // An accepted 0->1 change counts on the same edge filt takes it.
        assign w_rise = r_s2 & ~r_filt & (r_deb == DEB_LAST);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_s1   <= 1'b0;
                r_s2   <= 1'b0;
                r_filt <= 1'b0;
                r_deb  <= '0;
                r_cnt  <= '0;
                r_led  <= 1'b0;
            end else begin
                r_s1 <= sensor[g];
                r_s2 <= r_s1;
                if (r_s2 == r_filt) begin
                    r_deb <= '0;
                end else if (r_deb == DEB_LAST) begin
                    r_filt <= r_s2;
                    r_deb  <= '0;
                end else begin
                    r_deb <= r_deb + DEB_W'(1);
                end
                if (r_state != RUN || clear) begin
                    r_cnt <= '0;
                end else if (w_rise && r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + DATA_W'(1);
                end
                r_led <= (r_thr[g] != '0) && (r_cnt >= r_thr[g]);
            end
        end

        assign led[g] = r_led;
    end
endmodule

// File: tb/tb_sensor_array.sv
// Self-checking bench for sensor_array: table-driven load sequence plus
// directed debounce, saturation, clear, reload and mid-load reset sequences.
module tb_sensor_array;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] sensor;
    logic       clear;
    logic       reload;
    logic [3:0] led;
    logic       busy;
    logic [7:0] rom_mem [16];

    int n_vec = 0;
    int n_err = 0;

    sensor_array_if #(.ADDR_W(4), .DATA_W(8)) rom_bus ();

    sensor_array #(
        .CHANNELS(4), .DATA_W(8), .ADDR_W(4), .ROM_BASE(0), .DEBOUNCE(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sensor(sensor), .clear(clear),
        .reload(reload), .led(led), .busy(busy), .rom(rom_bus)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data valid the cycle after ce/re are sampled.
    always @(posedge clk) begin
        if (rom_bus.rom_ce && rom_bus.rom_re) rom_bus.rom_data <= rom_mem[rom_bus.rom_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst_n;
        logic       clr;
        logic       rld;
        logic [3:0] e_led;
        logic       e_busy;
        logic       e_ce;
        logic       e_re;
        logic [3:0] e_addr;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic apply_vec(input int k);
        @(negedge clk);
        reset_n = vecs[k].rst_n;
        clear   = vecs[k].clr;
        reload  = vecs[k].rld;
        @(posedge clk);
        #1;
        check($sformatf("vec%0d", k),
              {21'd0, led, busy, rom_bus.rom_ce, rom_bus.rom_re, rom_bus.rom_addr},
              {21'd0, vecs[k].e_led, vecs[k].e_busy, vecs[k].e_ce, vecs[k].e_re, vecs[k].e_addr});
    endtask

    task automatic pulse(input int ch, input int high_cycles);
        @(negedge clk);
        sensor[ch] = 1'b1;
        repeat (high_cycles) @(negedge clk);
        sensor[ch] = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic check_thr(input string nm, input logic [7:0] t0, input logic [7:0] t1,
                             input logic [7:0] t2, input logic [7:0] t3);
        check({nm, "_thr0"}, 32'(dut.r_thr[0]), 32'(t0));
        check({nm, "_thr1"}, 32'(dut.r_thr[1]), 32'(t1));
        check({nm, "_thr2"}, 32'(dut.r_thr[2]), 32'(t2));
        check({nm, "_thr3"}, 32'(dut.r_thr[3]), 32'(t3));
    endtask

    initial begin
        int n_busy;

        reset_n = 1'b0;
        sensor  = 4'b0;
        clear   = 1'b0;
        reload  = 1'b0;
        for (int i = 0; i < 16; i++) rom_mem[i] = 8'h00;
        rom_mem[0] = 8'd2;
        rom_mem[1] = 8'd0;
        rom_mem[2] = 8'd5;
        rom_mem[3] = 8'd1;
        rom_mem[4] = 8'd7;

        // rst_n clr rld | led busy ce re addr; clear/reload while busy are ignored
        vecs[0] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h2};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h3};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};

        repeat (2) @(negedge clk);
        for (int k = 0; k < 10; k++) apply_vec(k);
        check_thr("load", 8'd2, 8'd0, 8'd5, 8'd1);

        // Debounce: 2-cycle pulse ignored, 3-cycle pulse counted
        pulse(0, 2);
        check("deb_short_cnt", 32'(dut.gen_ch[0].r_cnt), 32'd0);
        pulse(0, 3);
        check("deb_valid_cnt", 32'(dut.gen_ch[0].r_cnt), 32'd1);
        check("deb_led_below_thr", 32'(led[0]), 32'd0);

        // Third event reaches thr[0]=2: count at edge 4, LED at edge 5
        @(negedge clk);
        sensor[0] = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check("lat_led_edge4", 32'(led[0]), 32'd0);
        check("lat_cnt_edge4", 32'(dut.gen_ch[0].r_cnt), 32'd2);
        @(posedge clk);
        #1;
        check("lat_led_edge5", 32'(led[0]), 32'd1);
        @(negedge clk);
        sensor[0] = 1'b0;
        repeat (6) @(negedge clk);

        // Disabled channel saturates without lighting; thr=1 lights on one event
        for (int p = 0; p < 300; p++) pulse(1, 4);
        check("sat_cnt1", 32'(dut.gen_ch[1].r_cnt), 32'd255);
        check("sat_led1", 32'(led[1]), 32'd0);
        pulse(3, 4);
        check("thr1_led", 32'(led), 32'b1001);

        // Clear sampled on the edge filt[2] rises
        @(negedge clk);
        sensor[2] = 1'b1;
        repeat (4) @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        check("clr_filt2_rose", 32'(dut.gen_ch[2].r_filt), 32'd1);
        check("clr_cnt2", 32'(dut.gen_ch[2].r_cnt), 32'd0);
        check("clr_cnt1", 32'(dut.gen_ch[1].r_cnt), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        @(posedge clk);
        #1;
        check("clr_led_next", 32'(led), 32'd0);
        @(negedge clk);
        sensor[2] = 1'b0;
        repeat (6) @(negedge clk);

        // Reload in RUN with a second reload pulsed while busy
        pulse(3, 4);
        check("pre_reload_led3", 32'(led[3]), 32'd1);
        rom_mem[0] = 8'd1;
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        check("reload_busy_rise", 32'(busy), 32'd1);
        n_busy = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            reload = (c == 2);
            @(posedge clk);
            #1;
            if (busy) n_busy++;
            else break;
        end
        reload = 1'b0;
        check("reload_busy_cycles", 32'(n_busy), 32'd8);
        check("reload_cnt3", 32'(dut.gen_ch[3].r_cnt), 32'd0);
        check("reload_led", 32'(led), 32'd0);
        check_thr("reload", 8'd1, 8'd0, 8'd5, 8'd1);
        repeat (4) @(negedge clk);
        check("reload_no_rerun", 32'(busy), 32'd0);
        pulse(0, 4);
        check("reload_led0", 32'(led), 32'b0001);

        // Reset asserted during the third LOAD_WAIT, then a full reload
        for (int k = 0; k < 7; k++) apply_vec(k);
        reset_n = 1'b0;
        #1;
        check("midrst_outs", {21'd0, led, busy, rom_bus.rom_ce, rom_bus.rom_re, rom_bus.rom_addr},
              {21'd0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0});
        check("midrst_thr0", 32'(dut.r_thr[0]), 32'd0);
        for (int k = 1; k < 10; k++) apply_vec(k);
        check_thr("midrst", 8'd1, 8'd0, 8'd5, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
